// File: rtl/fifo_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_queue_if
//  Description : Bundles the request/response signals of fifo_queue.
//                master : the producer/consumer driving push/pop/clr_err
//                slave  : the FIFO itself
//  Signals     : push, din, pop, clr_err      (master -> slave)
//                dout, dout_valid, count,
//                empty, full, almost_full,
//                almost_empty, overflow,
//                underflow                    (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_queue_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int c_CW = $clog2(DEPTH) + 1;

  logic             push;
  logic [WIDTH-1:0] din;
  logic             pop;
  logic             clr_err;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [c_CW-1:0]  count;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, din, pop, clr_err,
    input  dout, dout_valid, count, empty, full,
           almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  push, din, pop, clr_err,
    output dout, dout_valid, count, empty, full,
           almost_full, almost_empty, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/fifo_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_queue
//  Description : Synchronous single-clock FIFO with registered read data,
//                occupancy count, level flags and sticky error flags.
//  Ports       : clk   - clock, all state changes on the rising edge
//                rstn  - synchronous active-low reset
//                bus   - fifo_queue_if.slave (push/din/pop/clr_err in,
//                        dout/dout_valid/count/status flags out)
//  Parameters  : WIDTH    - data width in bits
//                DEPTH    - entry count, power of two, >= 2
//                AF_LEVEL - almost_full asserted when count >= AF_LEVEL
//                AE_LEVEL - almost_empty asserted when count <= AE_LEVEL
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_queue #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  wire             clk,
  input  wire             rstn,
  fifo_queue_if.slave     bus
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;

  localparam logic [c_AW-1:0] c_PTR_ONE   = c_AW'(1);
  localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);
  localparam logic [c_CW-1:0] c_CNT_ZERO  = '0;
  localparam logic [c_CW-1:0] c_CNT_FULL  = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_CNT_AF    = c_CW'(AF_LEVEL);
  localparam logic [c_CW-1:0] c_CNT_AE    = c_CW'(AE_LEVEL);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_overflow;
  logic             r_underflow;

  // --------------------------------------------------------------------------
  // Status flags, decoded from the registered occupancy only
  // --------------------------------------------------------------------------
  logic w_empty;
  logic w_full;
  logic w_almost_full;
  logic w_almost_empty;

  assign w_empty        = (r_count == c_CNT_ZERO);
  assign w_full         = (r_count == c_CNT_FULL);
  assign w_almost_full  = (r_count >= c_CNT_AF);
  assign w_almost_empty = (r_count <= c_CNT_AE);

  // --------------------------------------------------------------------------
  // Request acceptance
  // A push while full is still accepted when a pop frees a slot in the same
  // cycle. A pop while empty is never accepted, even with a concurrent push,
  // because the new entry is not yet readable.
  // --------------------------------------------------------------------------
  logic w_pop_acc;
  logic w_push_acc;
  logic w_ovf_evt;
  logic w_unf_evt;

  assign w_pop_acc  = bus.pop  & ~w_empty;
  assign w_push_acc = bus.push & (~w_full | w_pop_acc);
  assign w_ovf_evt  = bus.push & ~w_push_acc;
  assign w_unf_evt  = bus.pop  &  w_empty;

  // --------------------------------------------------------------------------
  // Storage array: deliberately not reset. Writes are gated by rstn so that a
  // push presented during reset leaves no trace.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rstn && w_push_acc) begin
      r_mem[r_wr_ptr] <= bus.din;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, occupancy and read data
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= w_pop_acc;

      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end

      if (w_pop_acc) begin
        // Read-before-write on the same slot is safe: when full with a
        // concurrent push, wr_ptr == rd_ptr and the old entry is read here.
        r_dout   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end

      unique case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sticky error flags: a fresh error event takes priority over clr_err
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end else if (bus.clr_err) begin
        r_overflow <= 1'b0;
      end

      if (w_unf_evt) begin
        r_underflow <= 1'b1;
      end else if (bus.clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.dout         = r_dout;
  assign bus.dout_valid   = r_dout_valid;
  assign bus.count        = r_count;
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.almost_full  = w_almost_full;
  assign bus.almost_empty = w_almost_empty;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule
`default_nettype wire
